// File: rtl/z88_pkg.sv
// Shared types and constants for the Blink MMU and its wait-state generator.
package z88_pkg;

    // Physical region selected by the top bits of the physical address
    typedef enum logic [2:0] {
        REG_ROM,
        REG_RAM,
        REG_CARD1,
        REG_CARD2,
        REG_CARD3,
        REG_NONE
    } region_t;

    // Wait generator states, also exported for observation
    typedef enum logic [1:0] {
        WS_IDLE,
        WS_WAIT,
        WS_HOLD
    } wait_state_t;

    localparam logic [7:0] DEF_COM_PORT  = 8'hB0;
    localparam logic [7:0] DEF_SR_PORT   = 8'hD0;
    localparam logic [7:0] DEF_RAM0_BANK = 8'h20;

    // COM bit that swaps bank RAM0_BANK into 0x0000-0x1FFF
    localparam int RAMS_BIT = 2;

    // Slot 0 holds ROM (lower half) and RAM (upper half); slots 1..3 are cards
    function automatic region_t region_of(input logic [2:0] top);
        region_t r;
        casez (top)
            3'b000:  r = REG_ROM;
            3'b001:  r = REG_RAM;
            3'b01?:  r = REG_CARD1;
            3'b10?:  r = REG_CARD2;
            3'b11?:  r = REG_CARD3;
            default: r = REG_NONE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/z88_wait_gen.sv
// Wait-state generator: stretches a memory access by a per-region count.
// Handshake: a new access is recognised once per mreq_n low period; wait_n is
// held low (combinationally from the detecting cycle) for exactly i_ws cycles,
// then stays high until mreq_n rises and the FSM re-arms.
module z88_wait_gen
    import z88_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [3:0]  i_ws,
    input  logic        i_mreq_n,
    output logic        o_wait_n,
    output wait_state_t o_state
);

    wait_state_t r_state;
    wait_state_t w_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;

    // State and counter registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= WS_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state and wait output; the detecting cycle already counts as one
    // wait cycle, so the counter holds the wait cycles still to come.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        o_wait_n   = 1'b1;
        case (r_state)
            WS_IDLE: begin
                if (i_start) begin
                    if (i_ws == 4'd0) begin
                        w_next = WS_HOLD;
                    end else begin
                        o_wait_n   = 1'b0;
                        w_cnt_next = i_ws - 4'd1;
                        w_next     = (i_ws == 4'd1) ? WS_HOLD : WS_WAIT;
                    end
                end
            end
            WS_WAIT: begin
                if (i_mreq_n) begin
                    w_next     = WS_IDLE;
                    w_cnt_next = 4'd0;
                end else begin
                    o_wait_n = 1'b0;
                    if (r_cnt <= 4'd1) begin
                        w_next     = WS_HOLD;
                        w_cnt_next = 4'd0;
                    end else begin
                        w_cnt_next = r_cnt - 4'd1;
                    end
                end
            end
            WS_HOLD: begin
                if (i_mreq_n) w_next = WS_IDLE;
            end
            default: w_next = WS_IDLE;
        endcase
        // Reset releases the CPU immediately, even mid-access
        if (!i_rst_n) o_wait_n = 1'b1;
    end

    assign o_state = r_state;

endmodule

// File: rtl/z88_blink_mmu.sv
// Blink MMU: segment/COM registers, 16->22 bit address mapping, slot decode,
// strobes, read-data steering and per-region wait states.
module z88_blink_mmu
    import z88_pkg::*;
#(
    parameter int unsigned SEGBITS   = 8,
    parameter int unsigned PHYS_AW   = SEGBITS + 14,
    parameter logic [7:0]  COM_PORT  = DEF_COM_PORT,
    parameter logic [7:0]  SR_PORT   = DEF_SR_PORT,
    parameter logic [7:0]  RAM0_BANK = DEF_RAM0_BANK,
    parameter int unsigned ROM_WS    = 1,
    parameter int unsigned RAM_WS    = 0,
    parameter int unsigned CARD_WS   = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [15:0]        cpu_a,
    input  logic [7:0]         cpu_do,
    output logic [7:0]         cpu_di,
    input  logic               cpu_mreq_n,
    input  logic               cpu_iorq_n,
    input  logic               cpu_rd_n,
    input  logic               cpu_wr_n,
    input  logic               cpu_m1_n,
    output logic               cpu_wait_n,
    output logic [PHYS_AW-3:0] mem_a,
    output logic [7:0]         mem_do,
    output logic               mem_oe_n,
    output logic               mem_we_n,
    output logic               rom_ce_n,
    output logic               ram_ce_n,
    output logic [2:0]         card_ce_n,
    input  logic [7:0]         rom_di,
    input  logic [7:0]         ram_di,
    input  logic [7:0]         card_di,
    output logic [7:0]         com,
    output logic [1:0]         dbg_wait_state
);

    logic [7:0]         r_com;
    logic [SEGBITS-1:0] r_sr [4];
    logic               r_wr_seen;

    logic               w_mreq;
    logic               w_io;
    logic               w_io_wr;
    logic               w_io_rd;
    logic               w_com_hit;
    logic [3:0]         w_sr_hit;
    logic               w_reg_hit;
    logic [7:0]         w_reg_val;
    logic [PHYS_AW-1:0] w_phys;
    region_t            w_region;
    logic [3:0]         w_ws;
    logic               w_start;
    wait_state_t        w_wait_state;

    // Strobes are masked while in reset so no slot is selected then
    assign w_mreq  = !cpu_mreq_n && reset_n;
    // Interrupt acknowledge (M1 with IORQ) is not a port access
    assign w_io    = !cpu_iorq_n && cpu_m1_n && reset_n;
    assign w_io_wr = w_io && !cpu_wr_n;
    assign w_io_rd = w_io && !cpu_rd_n;

    // Port decode and register readback value
    always_comb begin
        w_com_hit = (cpu_a[7:0] == COM_PORT);
        w_sr_hit  = 4'b0000;
        w_reg_val = 8'hFF;
        if (w_com_hit) w_reg_val = r_com;
        for (int n = 0; n < 4; n++) begin
            if (cpu_a[7:0] == SR_PORT + 8'(n)) begin
                w_sr_hit[n] = 1'b1;
                w_reg_val   = 8'(r_sr[n]);
            end
        end
        w_reg_hit = w_com_hit || (w_sr_hit != 4'b0000);
    end

    // I/O register writes: latch once per IORQ low period
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_com     <= 8'h00;
            r_wr_seen <= 1'b0;
            for (int n = 0; n < 4; n++) r_sr[n] <= '0;
        end else begin
            if (cpu_iorq_n)   r_wr_seen <= 1'b0;
            else if (w_io_wr) r_wr_seen <= 1'b1;
            if (w_io_wr && !r_wr_seen) begin
                if (w_com_hit) r_com <= cpu_do;
                for (int n = 0; n < 4; n++) begin
                    if (w_sr_hit[n]) r_sr[n] <= SEGBITS'(cpu_do);
                end
            end
        end
    end

    // Logical-to-physical mapping; 0x2000-0x3FFF is the upper half of the
    // bank pair selected by SR0 (SR0 bit 0 picks the 8K half)
    always_comb begin
        case (cpu_a[15:14])
            2'b11:   w_phys = {r_sr[3], cpu_a[13:0]};
            2'b10:   w_phys = {r_sr[2], cpu_a[13:0]};
            2'b01:   w_phys = {r_sr[1], cpu_a[13:0]};
            default: begin
                if (cpu_a[13])
                    w_phys = {r_sr[0][SEGBITS-1:1], 1'b0, r_sr[0][0], cpu_a[12:0]};
                else if (r_com[RAMS_BIT])
                    w_phys = {SEGBITS'(RAM0_BANK), cpu_a[13:0]};
                else
                    w_phys = {{SEGBITS{1'b0}}, cpu_a[13:0]};
            end
        endcase
    end

    assign w_region = region_of(w_phys[PHYS_AW-1 -: 3]);

    // Wait-state count of the addressed region
    always_comb begin
        case (w_region)
            REG_ROM:   w_ws = 4'(ROM_WS);
            REG_RAM:   w_ws = 4'(RAM_WS);
            REG_CARD1,
            REG_CARD2,
            REG_CARD3: w_ws = 4'(CARD_WS);
            default:   w_ws = 4'd0;
        endcase
    end

    // Refresh (MREQ without RD/WR) never starts a wait sequence
    assign w_start = w_mreq && (!cpu_rd_n || !cpu_wr_n);

    z88_wait_gen u_wait_gen (
        .i_clk    (clk),
        .i_rst_n  (reset_n),
        .i_start  (w_start),
        .i_ws     (w_ws),
        .i_mreq_n (cpu_mreq_n),
        .o_wait_n (cpu_wait_n),
        .o_state  (w_wait_state)
    );

    assign mem_a     = w_phys[PHYS_AW-3:0];
    assign mem_do    = cpu_do;
    assign mem_oe_n  = !(w_mreq && !cpu_rd_n);
    // ROM is never write-strobed
    assign mem_we_n  = !(w_mreq && !cpu_wr_n && (w_region != REG_ROM));
    assign rom_ce_n  = !(w_mreq && (w_region == REG_ROM));
    assign ram_ce_n  = !(w_mreq && (w_region == REG_RAM));
    assign card_ce_n = {!(w_mreq && (w_region == REG_CARD3)),
                        !(w_mreq && (w_region == REG_CARD2)),
                        !(w_mreq && (w_region == REG_CARD1))};
    assign com            = r_com;
    assign dbg_wait_state = w_wait_state;

    // Read data steering: register readback, then slot data, else open bus
    always_comb begin
        cpu_di = 8'hFF;
        if (w_io_rd) begin
            if (w_reg_hit) cpu_di = w_reg_val;
        end else if (w_mreq) begin
            case (w_region)
                REG_ROM:   cpu_di = rom_di;
                REG_RAM:   cpu_di = ram_di;
                REG_CARD1,
                REG_CARD2,
                REG_CARD3: cpu_di = card_di;
                default:   cpu_di = 8'hFF;
            endcase
        end
    end

endmodule

// File: tb/tb_z88_blink_mmu.sv
// Bench for z88_blink_mmu: directed steps plus random I/O and memory cycles,
// checked against an arithmetic model of the memory map.
module tb_z88_blink_mmu;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_do;
    logic [7:0]  cpu_di;
    logic        cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n;
    logic        cpu_wait_n;
    logic [19:0] mem_a;
    logic [7:0]  mem_do;
    logic        mem_oe_n, mem_we_n, rom_ce_n, ram_ce_n;
    logic [2:0]  card_ce_n;
    logic [7:0]  rom_di, ram_di, card_di;
    logic [7:0]  com;
    logic [1:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference register state
    logic [7:0] m_com;
    logic [7:0] m_sr [4];

    z88_blink_mmu dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cpu_a          (cpu_a),
        .cpu_do         (cpu_do),
        .cpu_di         (cpu_di),
        .cpu_mreq_n     (cpu_mreq_n),
        .cpu_iorq_n     (cpu_iorq_n),
        .cpu_rd_n       (cpu_rd_n),
        .cpu_wr_n       (cpu_wr_n),
        .cpu_m1_n       (cpu_m1_n),
        .cpu_wait_n     (cpu_wait_n),
        .mem_a          (mem_a),
        .mem_do         (mem_do),
        .mem_oe_n       (mem_oe_n),
        .mem_we_n       (mem_we_n),
        .rom_ce_n       (rom_ce_n),
        .ram_ce_n       (ram_ce_n),
        .card_ce_n      (card_ce_n),
        .rom_di         (rom_di),
        .ram_di         (ram_di),
        .card_di        (card_di),
        .com            (com),
        .dbg_wait_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Physical address from the map rules, in plain arithmetic
    function automatic int unsigned model_phys(input logic [15:0] a);
        int unsigned ai;
        int unsigned p;
        ai = int'(a);
        if (ai >= 16384)
            p = int'(m_sr[ai / 16384]) * 16384 + ai % 16384;
        else if (ai >= 8192)
            p = (int'(m_sr[0]) / 2) * 32768 + (int'(m_sr[0]) % 2) * 8192 + ai % 8192;
        else
            p = (((m_com & 8'h04) != 8'h00) ? 32 : 0) * 16384 + ai;
        return p;
    endfunction

    // 0 = ROM, 1 = RAM, 2..4 = card slot 1..3 (512K per half-slot)
    function automatic int model_region(input int unsigned p);
        int slot;
        slot = int'(p / 524288);
        return (slot < 2) ? slot : 1 + slot / 2;
    endfunction

    function automatic int model_ws(input int region);
        if (region == 0) return 1;
        if (region == 1) return 0;
        return 2;
    endfunction

    function automatic logic [7:0] model_io_read(input logic [7:0] port);
        if (port == 8'hB0) return m_com;
        if (port >= 8'hD0 && port <= 8'hD3) return m_sr[port - 8'hD0];
        return 8'hFF;
    endfunction

    task automatic model_io_write(input logic [7:0] port, input logic [7:0] data);
        if (port == 8'hB0) m_com = data;
        else if (port >= 8'hD0 && port <= 8'hD3) m_sr[port - 8'hD0] = data;
    endtask

    task automatic model_reset();
        m_com = 8'h00;
        for (int n = 0; n < 4; n++) m_sr[n] = 8'h00;
    endtask

    // One memory read or write cycle, checked against the model
    task automatic mem_cycle(input logic [15:0] a, input bit is_wr, input logic [7:0] d);
        int unsigned p;
        int          reg_i;
        int          got_ws;
        logic [7:0]  exp_di;
        logic [2:0]  exp_card;
        p     = model_phys(a);
        reg_i = model_region(p);
        rom_di  = 8'($urandom);
        ram_di  = 8'($urandom);
        card_di = 8'($urandom);
        exp_di   = (reg_i == 0) ? rom_di : (reg_i == 1) ? ram_di : card_di;
        exp_card = 3'b111;
        if (reg_i >= 2) exp_card[reg_i - 2] = 1'b0;
        cpu_a      = a;
        cpu_do     = d;
        cpu_mreq_n = 1'b0;
        if (is_wr) cpu_wr_n = 1'b0;
        else       cpu_rd_n = 1'b0;
        @(negedge clk);
        chk("mem_a", 32'(mem_a), p % 1048576);
        chk("rom_ce_n", 32'(rom_ce_n), 32'(reg_i != 0));
        chk("ram_ce_n", 32'(ram_ce_n), 32'(reg_i != 1));
        chk("card_ce_n", 32'(card_ce_n), 32'(exp_card));
        chk("mem_oe_n", 32'(mem_oe_n), 32'(is_wr));
        chk("mem_we_n", 32'(mem_we_n), 32'(!(is_wr && reg_i != 0)));
        if (is_wr) chk("mem_do", 32'(mem_do), 32'(d));
        else       chk("cpu_di_mem", 32'(cpu_di), 32'(exp_di));
        got_ws = 0;
        for (int i = 0; i < 20 && cpu_wait_n === 1'b0; i++) begin
            got_ws++;
            @(negedge clk);
        end
        if (cpu_wait_n !== 1'b1) chk("wait_timeout", 32'(cpu_wait_n), 32'd1);
        chk("wait_cycles", 32'(got_ws), 32'(model_ws(reg_i)));
        tick();
        cpu_mreq_n = 1'b1;
        cpu_rd_n   = 1'b1;
        cpu_wr_n   = 1'b1;
        tick();
    endtask

    // I/O write held for two edges; data changes after the first edge and
    // must not be latched again
    task automatic io_write(input logic [7:0] port, input logic [7:0] data, input bit ack);
        cpu_a      = {8'($urandom), port};
        cpu_do     = data;
        cpu_iorq_n = 1'b0;
        cpu_wr_n   = 1'b0;
        cpu_m1_n   = ack ? 1'b0 : 1'b1;
        tick();
        cpu_do = ~data;
        tick();
        cpu_iorq_n = 1'b1;
        cpu_wr_n   = 1'b1;
        cpu_m1_n   = 1'b1;
        tick();
        if (!ack) model_io_write(port, data);
        chk("com_reg", 32'(com), 32'(m_com));
    endtask

    task automatic io_read(input logic [7:0] port);
        cpu_a      = {8'($urandom), port};
        cpu_iorq_n = 1'b0;
        cpu_rd_n   = 1'b0;
        @(negedge clk);
        chk("cpu_di_io", 32'(cpu_di), 32'(model_io_read(port)));
        chk("io_oe_n", 32'(mem_oe_n), 32'd1);
        tick();
        cpu_iorq_n = 1'b1;
        cpu_rd_n   = 1'b1;
        tick();
    endtask

    initial begin
        logic [7:0] port;
        reset_n    = 1'b0;
        cpu_a      = 16'h0000;
        cpu_do     = 8'h00;
        cpu_mreq_n = 1'b1;
        cpu_iorq_n = 1'b1;
        cpu_rd_n   = 1'b1;
        cpu_wr_n   = 1'b1;
        cpu_m1_n   = 1'b1;
        rom_di     = 8'h00;
        ram_di     = 8'h00;
        card_di    = 8'h00;
        model_reset();
        tick();
        tick();
        chk("rst_wait_n", 32'(cpu_wait_n), 32'd1);
        chk("rst_com", 32'(com), 32'd0);
        chk("rst_rom_ce_n", 32'(rom_ce_n), 32'd1);
        chk("rst_we_n", 32'(mem_we_n), 32'd1);
        chk("rst_cpu_di", 32'(cpu_di), 32'hFF);
        chk("rst_state", 32'(dbg_state), 32'd0);
        reset_n = 1'b1;
        tick();

        // ROM read at 0x0005, one wait cycle
        mem_cycle(16'h0005, 1'b0, 8'h00);
        // RAMS: 0x0100 moves to bank 0x20
        io_write(8'hB0, 8'h04, 1'b0);
        mem_cycle(16'h0100, 1'b0, 8'h00);
        io_read(8'hB0);
        // SR1 = 0x41 -> card slot 1, two wait cycles
        io_write(8'hD1, 8'h41, 1'b0);
        mem_cycle(16'h4123, 1'b0, 8'h00);
        // SR0 = 0x21, 0x2010 -> RAM with A13 from SR0[0]
        io_write(8'hD0, 8'h21, 1'b0);
        mem_cycle(16'h2010, 1'b0, 8'h00);
        // ROM write suppressed, RAM write without wait
        io_write(8'hD3, 8'h05, 1'b0);
        mem_cycle(16'hC000, 1'b1, 8'h5A);
        mem_cycle(16'h0100, 1'b1, 8'hA5);
        io_read(8'hD3);
        io_read(8'h37);

        // Refresh cycle never waits
        cpu_a      = 16'h0005;
        cpu_mreq_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("refresh_wait_n", 32'(cpu_wait_n), 32'd1);
        end
        tick();
        cpu_mreq_n = 1'b1;
        tick();

        // Interrupt acknowledge on port 0xD2 leaves SR2 alone
        io_write(8'hD2, 8'h77, 1'b1);
        io_read(8'hD2);

        // Random I/O and memory traffic
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    case ($urandom_range(0, 6))
                        0:       port = 8'hB0;
                        1:       port = 8'hD0;
                        2:       port = 8'hD1;
                        3:       port = 8'hD2;
                        4:       port = 8'hD3;
                        default: port = 8'($urandom);
                    endcase
                    io_write(port, 8'($urandom), ($urandom_range(0, 7) == 0));
                end
                1: begin
                    port = ($urandom_range(0, 1) == 0) ? 8'(8'hD0 + 8'($urandom_range(0, 3))) : 8'($urandom);
                    io_read(port);
                end
                default: mem_cycle(16'($urandom), $urandom_range(0, 1) == 1, 8'($urandom));
            endcase
        end

        // Reset during a card wait sequence
        io_write(8'hD1, 8'h41, 1'b0);
        io_write(8'hB0, 8'h04, 1'b0);
        cpu_a      = 16'h4123;
        cpu_mreq_n = 1'b0;
        cpu_rd_n   = 1'b0;
        @(negedge clk);
        chk("pre_rst_wait_n", 32'(cpu_wait_n), 32'd0);
        @(posedge clk);
        #2;
        chk("mid_wait_n", 32'(cpu_wait_n), 32'd0);
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst_mid_wait_n", 32'(cpu_wait_n), 32'd1);
        chk("rst_mid_com", 32'(com), 32'd0);
        chk("rst_mid_card_ce_n", 32'(card_ce_n), 32'h7);
        tick();
        cpu_mreq_n = 1'b1;
        cpu_rd_n   = 1'b1;
        tick();
        reset_n = 1'b1;
        tick();
        io_read(8'hD0);
        io_read(8'hD1);
        io_read(8'hD2);
        io_read(8'hD3);
        mem_cycle(16'h4123, 1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
